// File: rtl/vmicro16_apb_arbiter.sv
// Round-robin arbiter sharing one APB bus between several core-side masters.
// Decodes the slave select and turns missing or hung slaves into error completions.
module vmicro16_apb_arbiter #(
  parameter int MASTERS   = 2,
  parameter int SLAVES    = 5,
  parameter int BUS_WIDTH = 16,
  parameter int SEL_LSB   = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MASTERS*BUS_WIDTH-1:0]   S_PADDR,
  input  logic [MASTERS-1:0]             S_PWRITE,
  input  logic [MASTERS-1:0]             S_PSELx,
  input  logic [MASTERS-1:0]             S_PENABLE,
  input  logic [MASTERS*BUS_WIDTH-1:0]   S_PWDATA,
  output logic [MASTERS*BUS_WIDTH-1:0]   S_PRDATA,
  output logic [MASTERS-1:0]             S_PREADY,
  output logic [MASTERS-1:0]             S_PSLVERR,
  output logic [BUS_WIDTH-1:0]           M_PADDR,
  output logic                           M_PWRITE,
  output logic [SLAVES-1:0]              M_PSELx,
  output logic                           M_PENABLE,
  output logic [BUS_WIDTH-1:0]           M_PWDATA,
  input  logic [BUS_WIDTH-1:0]           M_PRDATA,
  input  logic                           M_PREADY
);

  localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  state_t               state_q;
  logic [GW-1:0]        grant_q, last_q;
  logic [7:0]           cnt_q;
  logic [BUS_WIDTH-1:0] paddr_q, pwdata_q;
  logic                 pwrite_q, penable_q, decerr_q;
  logic [SLAVES-1:0]    psel_q;

  logic [GW-1:0]        grant_d, cand;
  logic                 found;
  logic [3:0]           sel_idx;
  logic [SLAVES-1:0]    psel_d;
  logic                 decerr_d;
  logic                 tmo_hit, done, err;
  logic [BUS_WIDTH-1:0] s_addr  [MASTERS];
  logic [BUS_WIDTH-1:0] s_wdata [MASTERS];

  // PENABLE from the cores carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      s_addr[m]  = S_PADDR[m*BUS_WIDTH +: BUS_WIDTH];
      s_wdata[m] = S_PWDATA[m*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // Scan from the master after the last one served; first requester wins.
  always_comb begin
    grant_d = last_q;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= MASTERS; i++) begin
      cand = GW'((int'(last_q) + i) % MASTERS);
      if (!found && S_PSELx[cand]) begin
        found   = 1'b1;
        grant_d = cand;
      end
    end
  end

  always_comb begin
    sel_idx  = s_addr[grant_d][SEL_LSB+3:SEL_LSB];
    psel_d   = '0;
    decerr_d = 1'b1;
    if (int'(sel_idx) < SLAVES) begin
      psel_d   = SLAVES'(1) << sel_idx;
      decerr_d = 1'b0;
    end
  end

  assign tmo_hit = (cnt_q == TMO_LAST);
  assign done    = (state_q == ACCESS) && (M_PREADY || decerr_q || tmo_hit);
  assign err     = (state_q == ACCESS) && (decerr_q || (tmo_hit && !M_PREADY));

  always_comb begin
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (GW'(m) == grant_q) begin
        S_PREADY[m]  = done;
        S_PSLVERR[m] = err;
        if (done)
          S_PRDATA[m*BUS_WIDTH +: BUS_WIDTH] = err ? '1 : M_PRDATA;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(MASTERS - 1);
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      decerr_q  <= 1'b0;
      psel_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|S_PSELx) begin
            grant_q  <= grant_d;
            paddr_q  <= s_addr[grant_d];
            pwdata_q <= s_wdata[grant_d];
            pwrite_q <= S_PWRITE[grant_d];
            psel_q   <= psel_d;
            decerr_q <= decerr_d;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            last_q    <= grant_q;
            cnt_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= RELEASE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_PADDR   = paddr_q;
  assign M_PWDATA  = pwdata_q;
  assign M_PWRITE  = pwrite_q;
  assign M_PSELx   = psel_q;
  assign M_PENABLE = penable_q;

endmodule
